led_frame_loader: RTL and testbench
===================================

# led_frame_loader

Upstream stage of the LED strip path. Receives a 6-LED colour frame from the MCU over a write-only SPI link (mode 0, MSB first). Assembles the frame in a shadow register and commits it atomically to the 144-bit `rgb` bus consumed by `led_shifter`. A partially transferred frame is never exposed.

## Interface
- `NUM_LEDS`, 6, LEDs per frame
- `BITS_PER_LED`, 24, colour bits per LED (GRB order, 8 bits each)
- `SYNC_STAGES`, 2, synchroniser depth on `sclk`, `sdi`, `cs_n`
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous assert, active-low
- `sclk`  in  1  SPI clock from MCU, asynchronous to `clk`
- `sdi`  in  1  SPI data from MCU, valid on `sclk` rising edge
- `cs_n`  in  1  SPI chip select, active-low, frames one transfer
- `rgb`  out  NUM_LEDS*BITS_PER_LED (144)  committed frame; LED0 = `rgb[143:120]`
- `frame_valid`  out  1  one-cycle pulse on the commit edge
- `frame_err`  out  1  one-cycle pulse when a transfer is discarded
- `busy`  out  1  high while a transfer is in progress (RECV or OVERFLOW)

## Operation
- Reset (`rst`=0) values: `rgb`=0, `frame_valid`=0, `frame_err`=0, `busy`=0, shadow=0, bit count=0, state IDLE.
  - Synchroniser flops reset to the idle levels: `cs_n`=1, `sclk`=0, `sdi`=0.
  - Reset asserted mid-transfer aborts the transfer and clears `rgb`.
- All pin inputs pass through `SYNC_STAGES` flops before use. An `sclk` rise is detected as the synced value being 1 and the previous value being 0. A `cs_n` rise is detected the same way.
- Shift rule: on each detected `sclk` rise in RECV, shadow <= {shadow[142:0], sdi_synced} and count <= count+1. The first bit received lands in `rgb[143]`.
- The bit count is 8 bits wide and saturates conceptually through OVERFLOW; it never wraps.
- States:
  - IDLE: `busy`=0. If synced `cs_n`==0 (level, not edge), clear count and go to RECV.
  - RECV: shift on each `sclk` rise.
    - If a shift would make count exceed FRAME_BITS (144), go to OVERFLOW and do not shift.
    - On a `cs_n` rise: count==144 goes to COMMIT; any other count, including 0, goes to ERROR.
  - OVERFLOW: ignore `sclk`. On a `cs_n` rise, go to ERROR.
  - COMMIT: `rgb` <= shadow and `frame_valid`=1 at the exiting edge; next state IDLE.
  - ERROR: `frame_err`=1 for this cycle; `rgb` unchanged; next state IDLE.
- Simultaneous `sclk` rise and `cs_n` rise in the same cycle: `cs_n` wins and the `sclk` edge is ignored.
- A new transfer starting while in COMMIT or ERROR is picked up from IDLE on the following cycle, by level. No bits are lost provided the `sclk` constraint below holds.

## Timing
- `clk` period must be ≤ 1/8 of the `sclk` period. `sclk` high and low times must each be ≥ 3 `clk` periods.
- `cs_n` setup to the first `sclk` rise and hold after the last `sclk` rise must each be ≥ 4 `clk` periods.
- Commit latency, with edge k being the first `clk` edge to sample `cs_n`=1 into sync stage 1:
  - At k+2 the FSM enters COMMIT.
  - At k+3 `rgb` updates and `frame_valid` is high for exactly the cycle after k+3.
- Error latency is identical: `frame_err` is high for the one cycle after edge k+3.
- `rgb` is stable except on commit edges and reset. The downstream block may sample it at any time.

## Structure
- Shared package `led_pkg`:
  - constants NUM_LEDS, BITS_PER_LED, FRAME_BITS = NUM_LEDS*BITS_PER_LED.
  - typedef `loader_state_t` enum {IDLE, RECV, OVERFLOW, COMMIT, ERROR}.
  - `led_shifter` should import the same constants.
- One sub-module, `sync_edge`: parameterised-depth synchroniser with async active-low reset, reset value, and rising-edge pulse output. Instantiate it for `sclk` and `cs_n`; `sdi` uses the synchroniser output only.

## Test plan
- Reset mid-frame: send 70 bits, then pulse `rst` low. Expect `rgb`=0, no `frame_valid`, `busy`=0. A subsequent valid frame commits normally.
- Valid frame: send 18 bytes 0x01..0x12. Expect `rgb[143:136]`=0x01, `rgb[7:0]`=0x12, and `frame_valid` high for one cycle exactly 4 edges after `cs_n` sampled high.
- Short frame: with `rgb` preloaded to 0xFF00AA…, send 143 bits. Expect one `frame_err` pulse and `rgb` unchanged. With 0 bits (a `cs_n` blip only), expect `frame_err` as well.
- Long frame: send 150 bits. Expect `busy` held, OVERFLOW entered at bit 145, `frame_err` on `cs_n` rise, `rgb` unchanged.
- Back-to-back frames: two valid frames with the minimum 4-cycle `cs_n` high gap. Expect two `frame_valid` pulses and a second `rgb` equal to frame 2.
- Edge collision: force the last synced `sclk` rise in the same cycle as the `cs_n` rise, after 144 bits. Expect a commit with the 144-bit data, and the colliding bit is not shifted in.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the LED strip path (loader and shifter).
package led_pkg;

   localparam int unsigned NUM_LEDS     = 6;
   localparam int unsigned BITS_PER_LED = 24;
   localparam int unsigned FRAME_BITS   = NUM_LEDS * BITS_PER_LED;
   localparam int unsigned CNT_W        = 8;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      OVERFLOW,
      COMMIT,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/led_frame_loader_if.sv
// SPI pins from the MCU plus the committed frame bus towards led_shifter.
interface led_frame_loader_if;
   import led_pkg::*;

   logic                  sclk;
   logic                  sdi;
   logic                  cs_n;
   logic [FRAME_BITS-1:0] rgb;
   logic                  frame_valid;
   logic                  frame_err;
   logic                  busy;

   modport master (
      output sclk, sdi, cs_n,
      input  rgb, frame_valid, frame_err, busy
   );

   modport slave (
      input  sclk, sdi, cs_n,
      output rgb, frame_valid, frame_err, busy
   );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with a rising-edge pulse on the synced level.
module sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c
);

   logic [STAGES-1:0] chain_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain_q <= {STAGES{RST_VAL}};
         prev_q  <= RST_VAL;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d};
         prev_q  <= chain_q[STAGES-1];
      end
   end

   assign q      = chain_q[STAGES-1];
   assign rise_c = q & ~prev_q;

endmodule

// File: rtl/led_frame_loader.sv
// SPI frame receiver: shifts bits into a shadow register and commits whole frames atomically to rgb.
module led_frame_loader
   import led_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   led_frame_loader_if.slave bus
);

   logic sclk_rise_c;
   logic sclk_s_unused;
   logic cs_n_s;
   logic cs_rise_c;
   logic sdi_s;
   logic sdi_rise_unused;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_s_unused), .rise_c(sclk_rise_c)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_n_s), .rise_c(cs_rise_c)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .clk(clk), .rst(rst), .d(bus.sdi), .q(sdi_s), .rise_c(sdi_rise_unused)
   );

   loader_state_t         state_q;
   loader_state_t         state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [FRAME_BITS-1:0] shadow_q;
   logic [FRAME_BITS-1:0] rgb_q;
   logic                  frame_valid_q;
   logic                  frame_err_q;
   logic                  busy_q;

   logic full_c;
   logic clr_c;
   logic shift_c;
   logic commit_c;
   logic err_c;
   logic busy_c;

   assign full_c = (cnt_q == CNT_W'(FRAME_BITS));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // A cs_n rise takes priority over an sclk rise seen in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (!cs_n_s) state_d = RECV;
         RECV: begin
            if (cs_rise_c)                state_d = full_c ? COMMIT : ERROR;
            else if (sclk_rise_c && full_c) state_d = OVERFLOW;
         end
         OVERFLOW: if (cs_rise_c) state_d = ERROR;
         COMMIT:   state_d = IDLE;
         ERROR:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // busy follows the next state so the registered flag lines up with the state register.
   always_comb begin
      clr_c    = 1'b0;
      shift_c  = 1'b0;
      commit_c = 1'b0;
      err_c    = 1'b0;
      busy_c   = 1'b0;
      clr_c    = (state_q == IDLE) && !cs_n_s;
      shift_c  = (state_q == RECV) && sclk_rise_c && !cs_rise_c && !full_c;
      commit_c = (state_q == COMMIT);
      err_c    = (state_q == ERROR);
      busy_c   = (state_d == RECV) || (state_d == OVERFLOW);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q         <= '0;
         shadow_q      <= '0;
         rgb_q         <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         if (clr_c)        cnt_q <= '0;
         else if (shift_c) cnt_q <= cnt_q + CNT_W'(1);
         if (shift_c)  shadow_q <= {shadow_q[FRAME_BITS-2:0], sdi_s};
         if (commit_c) rgb_q    <= shadow_q;
         frame_valid_q <= commit_c;
         frame_err_q   <= err_c;
         busy_q        <= busy_c;
      end
   end

   assign bus.rgb         = rgb_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader with a scoreboard of expected commit/error pulses.
module tb_led_frame_loader;
   import led_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   led_frame_loader_if bus();

   led_frame_loader #(.SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic                  v;
      logic                  e;
      logic [FRAME_BITS-1:0] rgb;
      int                    due;
   } exp_t;

   exp_t                  sbq[$];
   exp_t                  mon_e;
   logic [FRAME_BITS-1:0] exp_rgb = '0;
   int                    vectors = 0;
   int                    miscompares = 0;
   int                    cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [FRAME_BITS-1:0] obs,
                      input logic [FRAME_BITS-1:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Pop one expected event per pulse and check kind, latency and committed data.
   always @(negedge clk) begin
      if (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", FRAME_BITS'({bus.frame_valid, bus.frame_err}), '0);
         end else begin
            mon_e = sbq.pop_front();
            chk("pulse_kind", FRAME_BITS'({bus.frame_valid, bus.frame_err}),
                FRAME_BITS'({mon_e.v, mon_e.e}));
            chk("pulse_latency", FRAME_BITS'(cyc), FRAME_BITS'(mon_e.due));
            chk("pulse_rgb", bus.rgb, mon_e.rgb);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [FRAME_BITS-1:0] rnd_frame();
      logic [FRAME_BITS-1:0] f;
      f = '0;
      for (int i = 0; i < 5; i++) f = {f[FRAME_BITS-33:0], 32'($urandom)};
      return f;
   endfunction

   task automatic send_bits(input logic [FRAME_BITS-1:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         bus.sdi = (i < FRAME_BITS) ? d[FRAME_BITS-1-i] : 1'b1;
         repeat (4) @(negedge clk);
         bus.sclk = 1'b1;
         repeat (4) @(negedge clk);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic xfer(input logic [FRAME_BITS-1:0] d, input int n, input logic ok, input int gap);
      exp_t ent;
      bus.cs_n = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(d, n);
      repeat (4) @(negedge clk);
      chk("busy_in_xfer", FRAME_BITS'(bus.busy), FRAME_BITS'(1));
      if (ok) exp_rgb = d;
      ent = '{v: ok, e: !ok, rgb: exp_rgb, due: cyc + 4};
      sbq.push_back(ent);
      bus.cs_n = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   logic [FRAME_BITS-1:0] f1;
   logic [FRAME_BITS-1:0] f2;
   logic [FRAME_BITS-1:0] r;
   exp_t                  ent_c;

   initial begin
      bus.sclk = 1'b0;
      bus.sdi  = 1'b0;
      bus.cs_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_rgb", bus.rgb, '0);
      chk("reset_valid", FRAME_BITS'(bus.frame_valid), '0);
      chk("reset_err", FRAME_BITS'(bus.frame_err), '0);
      chk("reset_busy", FRAME_BITS'(bus.busy), '0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Bytes 0x01..0x12, first byte becomes LED0 green.
      for (int i = 0; i < 18; i++) f1[FRAME_BITS-1-8*i -: 8] = 8'(i + 1);
      xfer(f1, 144, 1'b1, 12);
      r = bus.rgb;
      chk("byte_first", FRAME_BITS'(r[143:136]), FRAME_BITS'(8'h01));
      chk("byte_last", FRAME_BITS'(r[7:0]), FRAME_BITS'(8'h12));
      chk("idle_busy", FRAME_BITS'(bus.busy), '0);

      // Reset in the middle of a transfer.
      bus.cs_n = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(rnd_frame(), 70);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      exp_rgb = '0;
      chk("midreset_rgb", bus.rgb, '0);
      chk("midreset_busy", FRAME_BITS'(bus.busy), '0);
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_reset_busy", FRAME_BITS'(bus.busy), '0);
      chk("post_reset_rgb", bus.rgb, '0);
      xfer(rnd_frame(), 144, 1'b1, 12);

      // Preload a known pattern, then short and empty transfers must leave it untouched.
      xfer({6{24'hFF00AA}}, 144, 1'b1, 12);
      xfer(rnd_frame(), 143, 1'b0, 12);
      chk("short_rgb", bus.rgb, exp_rgb);
      xfer(rnd_frame(), 0, 1'b0, 12);
      chk("blip_rgb", bus.rgb, exp_rgb);

      // Long transfer runs into overflow.
      xfer(rnd_frame(), 150, 1'b0, 12);
      chk("long_rgb", bus.rgb, exp_rgb);
      chk("long_busy_after", FRAME_BITS'(bus.busy), '0);

      // Back-to-back frames with the minimum cs_n high gap.
      f1 = rnd_frame();
      f2 = rnd_frame();
      xfer(f1, 144, 1'b1, 4);
      xfer(f2, 144, 1'b1, 12);
      chk("b2b_rgb", bus.rgb, f2);

      // Last sclk rise coincides with the cs_n rise: that bit must not be shifted in.
      f1 = {4{36'h1_2345_6789}};
      bus.cs_n = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(f1, 144);
      repeat (4) @(negedge clk);
      bus.sdi = 1'b1;
      exp_rgb = f1;
      ent_c = '{v: 1'b1, e: 1'b0, rgb: f1, due: cyc + 4};
      sbq.push_back(ent_c);
      bus.sclk = 1'b1;
      bus.cs_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (12) @(negedge clk);
      chk("collision_rgb", bus.rgb, f1);

      repeat (20) @(negedge clk);
      chk("sb_drained", FRAME_BITS'(sbq.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
